// File: rtl/video_pattern_checker_if.sv
// Video sink interface for video_pattern_checker.
// Carries control, video stream, geometry and checker status signals.
// The master modport drives the video stream (source/bench).
// The slave modport is the checker side.
// The first-error capture fields exist only when
// VIDEO_PATTERN_CHECKER_FIRST_ERR_EN is defined.
interface video_pattern_checker_if #(
  parameter int DSIZE = 24,
  parameter int CNT_W = 32
) ();
  logic             enable;
  logic             clr;
  logic             vsync;
  logic             hsync;
  logic             de;
  logic [DSIZE-1:0] data;
  logic [15:0]      hactive;
  logic [15:0]      vactive;

  logic             locked;
  logic             pix_err;
  logic             line_err;
  logic             frame_err;
  logic [15:0]      last_hcnt;
  logic [15:0]      last_vcnt;
  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] err_cnt;

`ifdef VIDEO_PATTERN_CHECKER_FIRST_ERR_EN
  logic             first_err_valid;
  logic [15:0]      first_err_x;
  logic [15:0]      first_err_y;
  logic [DSIZE-1:0] first_err_exp;
  logic [DSIZE-1:0] first_err_act;
`endif

  modport master (
    output enable, clr, vsync, hsync, de, data, hactive, vactive,
    input  locked, pix_err, line_err, frame_err, last_hcnt, last_vcnt,
           frame_cnt, err_cnt
`ifdef VIDEO_PATTERN_CHECKER_FIRST_ERR_EN
    , input first_err_valid, first_err_x, first_err_y, first_err_exp,
            first_err_act
`endif
  );

  modport slave (
    input  enable, clr, vsync, hsync, de, data, hactive, vactive,
    output locked, pix_err, line_err, frame_err, last_hcnt, last_vcnt,
           frame_cnt, err_cnt
`ifdef VIDEO_PATTERN_CHECKER_FIRST_ERR_EN
    , output first_err_valid, first_err_x, first_err_y, first_err_exp,
             first_err_act
`endif
  );
endinterface

// File: rtl/video_pattern_checker.sv
// Incrementing-pattern video checker.
// Verifies per-line 0,1,2,... pixel data during de, line length against
// hactive and frame height against vactive; reports lock, frame and error
// counters. Error pulses appear two cycles after the offending input.
// Optional first-error capture: define VIDEO_PATTERN_CHECKER_FIRST_ERR_EN.
//
// state | meaning
// SEEK  | waiting for a vsync rising edge, no checking or counting
// CHECK | checking pixels, lines and frames
module video_pattern_checker #(
  parameter int DSIZE = 24,
  parameter int CNT_W = 32
) (
  input logic                    pclk,
  input logic                    prst,
  video_pattern_checker_if.slave vid
);

  typedef enum logic {SEEK = 1'b0, CHECK = 1'b1} state_t;

  state_t           state_q, state_d;

  logic             vs1_q, vs2_q, de1_q, de2_q;
  logic [DSIZE-1:0] data1_q;
  logic [15:0]      hact1_q, vact1_q;

  logic [DSIZE-1:0] exp_q, exp_d;
  logic [15:0]      hcnt_q, hcnt_d;
  logic [15:0]      vcnt_q, vcnt_d;
  logic [15:0]      hsh_q, hsh_d;
  logic [15:0]      vsh_q, vsh_d;
  logic [15:0]      last_hcnt_q, last_hcnt_d;
  logic [15:0]      last_vcnt_q, last_vcnt_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             locked_q, locked_d;
  logic             line_bad_q, line_bad_d;
  logic             pix_bad_q, pix_bad_d;
  logic             pix_err_q, pix_err_d;
  logic             line_err_q, line_err_d;
  logic             frame_err_q, frame_err_d;

`ifdef VIDEO_PATTERN_CHECKER_FIRST_ERR_EN
  logic             fe_valid_q, fe_valid_d;
  logic [15:0]      fe_x_q, fe_x_d;
  logic [15:0]      fe_y_q, fe_y_d;
  logic [DSIZE-1:0] fe_exp_q, fe_exp_d;
  logic [DSIZE-1:0] fe_act_q, fe_act_d;
`endif

  logic             vs_rise, de_fall, checking;
  logic             pix_mis, line_mis, frame_mis;
  logic [DSIZE-1:0] exp_cmp;
  logic [15:0]      vcnt_line;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Stage 1 input registers and stage 2 copies used for edge detection
  always_ff @(posedge pclk) begin
    if (prst) begin
      vs1_q   <= 1'b0;
      vs2_q   <= 1'b0;
      de1_q   <= 1'b0;
      de2_q   <= 1'b0;
      data1_q <= '0;
      hact1_q <= '0;
      vact1_q <= '0;
    end else begin
      vs1_q   <= vid.vsync;
      vs2_q   <= vs1_q;
      de1_q   <= vid.de;
      de2_q   <= de1_q;
      data1_q <= vid.data;
      hact1_q <= vid.hactive;
      vact1_q <= vid.vactive;
    end
  end

  // Edge detection and registered-compare inputs
  always_comb begin
    vs_rise   = vs1_q & ~vs2_q;
    de_fall   = de2_q & ~de1_q;
    checking  = (state_q == CHECK) && vid.enable;
    // pixels inside vsync are always expected to be zero
    exp_cmp   = vs1_q ? '0 : exp_q;
    pix_mis   = checking && de1_q && (data1_q != exp_cmp);
    line_mis  = checking && de_fall && (hcnt_q != hsh_q);
    // a line closing on the same cycle as vs_rise still counts
    vcnt_line = de_fall ? sat_inc16(vcnt_q) : vcnt_q;
    frame_mis = checking && vs_rise && (vcnt_line != vsh_q);
  end

  // Next-state and counter update logic
  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    hcnt_d      = hcnt_q;
    vcnt_d      = vcnt_q;
    hsh_d       = hsh_q;
    vsh_d       = vsh_q;
    last_hcnt_d = last_hcnt_q;
    last_vcnt_d = last_vcnt_q;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    locked_d    = locked_q;
    line_bad_d  = line_bad_q;
    pix_bad_d   = pix_bad_q;
    pix_err_d   = 1'b0;
    line_err_d  = 1'b0;
    frame_err_d = 1'b0;
`ifdef VIDEO_PATTERN_CHECKER_FIRST_ERR_EN
    fe_valid_d  = fe_valid_q;
    fe_x_d      = fe_x_q;
    fe_y_d      = fe_y_q;
    fe_exp_d    = fe_exp_q;
    fe_act_d    = fe_act_q;
`endif

    // geometry shadows follow every vsync edge, checked or not
    if (vs_rise) begin
      hsh_d = hact1_q;
      vsh_d = vact1_q;
    end

    if (!vid.enable) begin
      state_d  = SEEK;
      locked_d = 1'b0;
    end else if (state_q == SEEK) begin
      if (vs_rise) begin
        state_d    = CHECK;
        exp_d      = '0;
        hcnt_d     = '0;
        vcnt_d     = '0;
        line_bad_d = 1'b0;
        pix_bad_d  = 1'b0;
      end
    end else begin
      if (de1_q) begin
        if (pix_mis) begin
          pix_err_d = 1'b1;
          pix_bad_d = 1'b1;
          if (err_cnt_q != {CNT_W{1'b1}})
            err_cnt_d = err_cnt_q + CNT_W'(1);
`ifdef VIDEO_PATTERN_CHECKER_FIRST_ERR_EN
          if (!fe_valid_q) begin
            fe_valid_d = 1'b1;
            fe_x_d     = hcnt_q;
            fe_y_d     = vcnt_q;
            fe_exp_d   = exp_cmp;
            fe_act_d   = data1_q;
          end
`endif
        end
        exp_d  = exp_cmp + DSIZE'(1);
        hcnt_d = sat_inc16(hcnt_q);
      end else begin
        exp_d = '0;
      end

      if (de_fall) begin
        last_hcnt_d = hcnt_q;
        if (line_mis) begin
          line_err_d = 1'b1;
          line_bad_d = 1'b1;
        end
        vcnt_d = vcnt_line;
        hcnt_d = '0;
      end

      if (vs1_q) begin
        exp_d  = '0;
        hcnt_d = '0;
      end

      if (vs_rise) begin
        last_vcnt_d = vcnt_line;
        frame_err_d = frame_mis;
        frame_cnt_d = frame_cnt_q + CNT_W'(1);
        locked_d    = ~(pix_bad_q | line_bad_q | pix_mis | line_mis | frame_mis);
        vcnt_d      = '0;
        line_bad_d  = 1'b0;
        pix_bad_d   = 1'b0;
      end

      if (pix_mis || line_mis || frame_mis)
        locked_d = 1'b0;
    end

    // clear beats any increment on the same cycle
    if (vid.clr) begin
      frame_cnt_d = '0;
      err_cnt_d   = '0;
`ifdef VIDEO_PATTERN_CHECKER_FIRST_ERR_EN
      fe_valid_d  = 1'b0;
      fe_x_d      = '0;
      fe_y_d      = '0;
      fe_exp_d    = '0;
      fe_act_d    = '0;
`endif
    end
  end

  // State, counter and status registers
  always_ff @(posedge pclk) begin
    if (prst) begin
      state_q     <= SEEK;
      exp_q       <= '0;
      hcnt_q      <= '0;
      vcnt_q      <= '0;
      hsh_q       <= '0;
      vsh_q       <= '0;
      last_hcnt_q <= '0;
      last_vcnt_q <= '0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
      locked_q    <= 1'b0;
      line_bad_q  <= 1'b0;
      pix_bad_q   <= 1'b0;
      pix_err_q   <= 1'b0;
      line_err_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      hcnt_q      <= hcnt_d;
      vcnt_q      <= vcnt_d;
      hsh_q       <= hsh_d;
      vsh_q       <= vsh_d;
      last_hcnt_q <= last_hcnt_d;
      last_vcnt_q <= last_vcnt_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
      locked_q    <= locked_d;
      line_bad_q  <= line_bad_d;
      pix_bad_q   <= pix_bad_d;
      pix_err_q   <= pix_err_d;
      line_err_q  <= line_err_d;
      frame_err_q <= frame_err_d;
    end
  end

`ifdef VIDEO_PATTERN_CHECKER_FIRST_ERR_EN
  // First pixel error capture registers
  always_ff @(posedge pclk) begin
    if (prst) begin
      fe_valid_q <= 1'b0;
      fe_x_q     <= '0;
      fe_y_q     <= '0;
      fe_exp_q   <= '0;
      fe_act_q   <= '0;
    end else begin
      fe_valid_q <= fe_valid_d;
      fe_x_q     <= fe_x_d;
      fe_y_q     <= fe_y_d;
      fe_exp_q   <= fe_exp_d;
      fe_act_q   <= fe_act_d;
    end
  end

  assign vid.first_err_valid = fe_valid_q;
  assign vid.first_err_x     = fe_x_q;
  assign vid.first_err_y     = fe_y_q;
  assign vid.first_err_exp   = fe_exp_q;
  assign vid.first_err_act   = fe_act_q;
`endif

  assign vid.locked    = locked_q;
  assign vid.pix_err   = pix_err_q;
  assign vid.line_err  = line_err_q;
  assign vid.frame_err = frame_err_q;
  assign vid.last_hcnt = last_hcnt_q;
  assign vid.last_vcnt = last_vcnt_q;
  assign vid.frame_cnt = frame_cnt_q;
  assign vid.err_cnt   = err_cnt_q;

endmodule

// File: doc/video_pattern_checker.md
Name: video_pattern_checker

Overview:
Downstream sink for the native video test-pattern generator. Consumes vsync/hsync/de/data in the pixel clock domain and checks the per-line incrementing pattern: 0,1,2,… during de, restarting at 0 on every line and frame. It also checks line length against hactive and frame height against vactive, and exposes lock, frame and error counters for bring-up and regression of the VDMA path.

Parameters:
DSIZE, 24, pixel data width checked; expected value wraps mod 2^DSIZE.
CNT_W, 32, width of frame_cnt and err_cnt.

Ports:
pclk      input   1      pixel clock; all logic on rising edge
prst      input   1      synchronous active-high reset
enable    input   1      checker enable; low forces SEEK
clr       input   1      one-cycle pulse; zeroes frame_cnt and err_cnt
vsync     input   1      vertical sync, active high
hsync     input   1      horizontal sync (passed through, unused by checks)
de        input   1      data enable
data      input   DSIZE  pixel data
hactive   input   16     expected pixels per line
vactive   input   16     expected active lines per frame
locked    output  1      pattern and geometry verified for last full frame
pix_err   output  1      one-cycle pulse per mismatching pixel
line_err  output  1      one-cycle pulse: line length != hactive
frame_err output  1      one-cycle pulse: line count != vactive
last_hcnt output  16     pixel count of last completed line
last_vcnt output  16     line count of last completed frame
frame_cnt output  CNT_W  completed frames since reset/clr
err_cnt   output  CNT_W  total pixel mismatches, saturating

Behaviour:
- All inputs are registered once (stage 1). Comparisons are registered (stage 2). pix_err/line_err/frame_err assert exactly 2 cycles after the offending input cycle.
- Reset (prst=1 at an edge): all outputs 0; state=SEEK; hcnt, vcnt and exp = 0; hactive/vactive shadows = 0.
- Edges are derived from stage-1 vs stage-2 copies: vs_rise, de_fall.
- State SEEK: no checking, no counting. On vs_rise with enable=1 → CHECK. hactive/vactive are latched into shadows on every vs_rise and are used for the following frame.
- State CHECK:
  - de=1 per cycle: compare data against exp. On mismatch, pix_err=1 and err_cnt+1, saturating at 2^CNT_W-1. Then exp <= exp+1 (wraps), hcnt+1 (saturates at 0xFFFF).
  - de=0: exp <= 0.
  - de_fall: last_hcnt <= hcnt. If hcnt != hactive shadow, line_err=1 and line_bad flag set. Then vcnt+1 (saturating), hcnt <= 0.
  - vs_rise: last_vcnt <= vcnt. If vcnt != vactive shadow, frame_err=1. frame_cnt+1 (wraps). locked <= no pix/line/frame error in the frame just ended. vcnt, line_bad and frame error flags are cleared.
- vsync=1 cycles force exp=0 and hcnt=0. Pixels with de=1 while vsync=1 are still checked against 0.
- Simultaneous de_fall and vs_rise: the line closes first, and its count is included in the vcnt compared at that vs_rise.
- Any pix_err/line_err/frame_err clears locked immediately, on the same cycle as the pulse.
- enable=0: next cycle state=SEEK and locked=0. All counters, last_hcnt and last_vcnt hold. No pulses are emitted.
- clr: frame_cnt=0 and err_cnt=0 next cycle. If clr coincides with an increment, clr wins. Other outputs are unaffected.
- First frame after entering CHECK: the vs_rise that entered CHECK does not count a frame. The first frame_cnt increment is at the next vs_rise.

Optional Feature:
Macro VIDEO_PATTERN_CHECKER_FIRST_ERR_EN.
- Defined: adds outputs first_err_valid (1), first_err_x (16), first_err_y (16), first_err_exp (DSIZE), first_err_act (DSIZE).
  - On the first pix_err after reset or clr, capture hcnt, vcnt, exp and data for that pixel and set first_err_valid.
  - Later errors do not overwrite the capture.
  - Cleared by prst and by clr.
- Undefined: these ports and registers do not exist. All other behaviour is unchanged.

Test Plan:
- hactive=8, vactive=4, clean pattern for 3 frames → locked=1 after 2nd vs_rise in CHECK; frame_cnt=2; err_cnt=0; last_hcnt=8; last_vcnt=4.
- Frame 2, line 1, pixel 3 data=0x000099 instead of 3 → one pix_err 2 cycles later; err_cnt=1; locked=0 at once; locked=1 again after next clean frame. With macro: first_err_x=3, y=1, exp=3, act=0x99.
- One line of 7 pixels with hactive=8 → single line_err; last_hcnt=7; vcnt still increments.
- 5 lines with vactive=4 → frame_err at vs_rise; last_vcnt=5; locked=0.
- enable=0 mid-frame, then 1 → no pulses while low; resync at next vs_rise; counters held throughout. clr coincident with a pix_err → err_cnt=0.
- prst asserted mid-line → all outputs 0 next cycle; state=SEEK; no checking until next vs_rise.
